program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Streams instruction words into a program memory, tracks a running checksum and holds the CPU
// until a load completes cleanly. Define LOADER_VERIFY_EN to add a readback/verify pass.
module program_loader #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W:0] Depth  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LenOne = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StWrite, StVerify, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W:0]   wptr_q;
  logic [ADDR_W:0]   len_q;
  logic [DATA_W-1:0] checksum_q;
  logic              busy_q;
  logic              done_q;
  logic              hold_q;

  logic [ADDR_W:0]   len_clamp;
  logic [ADDR_W:0]   len_last;
  logic              wr_last;

  assign len_clamp = (len > Depth) ? Depth : len;
  assign len_last  = len_q - LenOne;
  assign wr_last   = (wptr_q == len_last);

  assign in_ready  = (state_q == StWrite);
  // Abort and reset both suppress the write in the cycle they are seen.
  assign mem_we    = in_ready && in_valid && !abort && !rst;
  assign mem_waddr = wptr_q[ADDR_W-1:0];
  assign mem_wdata = in_data;

  assign busy      = busy_q;
  assign done      = done_q;
  assign cpu_hold  = hold_q;
  assign checksum  = checksum_q;

`ifdef LOADER_VERIFY_EN
  logic              error_q;
  logic [ADDR_W:0]   vptr_q;
  logic [DATA_W-1:0] vsum_q;
  logic [DATA_W-1:0] vsum_next;
  logic              v_last;
  logic              mismatch;

  assign vsum_next = vsum_q + mem_rdata;
  assign v_last    = (vptr_q == len_last);
  assign mismatch  = (vsum_next != checksum_q);
  assign mem_raddr = (state_q == StVerify) ? vptr_q[ADDR_W-1:0] : '0;
  assign error     = error_q;
`else
  logic [DATA_W-1:0] unused_rdata;

  assign unused_rdata = mem_rdata;
  assign mem_raddr    = '0;
  assign error        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wptr_q     <= '0;
      len_q      <= '0;
      checksum_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hold_q     <= 1'b1;
`ifdef LOADER_VERIFY_EN
      error_q    <= 1'b0;
      vptr_q     <= '0;
      vsum_q     <= '0;
`endif
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            checksum_q <= '0;
            wptr_q     <= '0;
            len_q      <= len_clamp;
`ifdef LOADER_VERIFY_EN
            error_q    <= 1'b0;
`endif
            if (len_clamp == '0) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= StWrite;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              hold_q  <= 1'b1;
            end
          end
        end

        StWrite: begin
          if (abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= 1'b1;
          end else if (in_valid) begin
            wptr_q     <= wptr_q + LenOne;
            checksum_q <= checksum_q + in_data;
            if (wr_last) begin
`ifdef LOADER_VERIFY_EN
              state_q <= StVerify;
              vptr_q  <= '0;
              vsum_q  <= '0;
`else
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
`endif
            end
          end
        end

`ifdef LOADER_VERIFY_EN
        StVerify: begin
          if (abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= 1'b1;
          end else begin
            vptr_q <= vptr_q + LenOne;
            vsum_q <= vsum_next;
            if (v_last) begin
              // Compare includes the word being read this cycle.
              error_q <= mismatch;
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              hold_q  <= mismatch;
            end
          end
        end
`endif

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          hold_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule
